snn_delay_layer: RTL



---
 rtl/snn_delay_layer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/snn_delay_layer.sv
// snn_delay_layer: fully-connected layer of leaky integrate-and-fire neurons
// with a programmable axonal delay on every synapse. Chain instances by
// feeding output_spikes of one layer into input_spikes of the next.
module snn_delay_layer #(
    parameter int N_IN      = 24,
    parameter int N_OUT     = 8,
    parameter int W_WIDTH   = 2,
    parameter int D_WIDTH   = 4,
    parameter int MEM_WIDTH = 6,
    parameter int P_WIDTH   = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              clear,
    input  logic [N_IN-1:0]                   input_spikes,
    input  logic [N_IN*N_OUT*W_WIDTH-1:0]     weights,
    input  logic [N_IN*N_OUT*D_WIDTH-1:0]     delays,
    input  logic [P_WIDTH-1:0]                threshold,
    input  logic [P_WIDTH-1:0]                decay,
    input  logic [P_WIDTH-1:0]                refractory_period,
    output logic [N_OUT*MEM_WIDTH-1:0]        membrane_potential_out,
    output logic [N_OUT-1:0]                  output_spikes
);

    localparam int MAX_D = (1 << D_WIDTH) - 1;
    // Synaptic accumulator: holds +/- N_IN * 2^(W_WIDTH-1) with a spare bit.
    localparam int ACC_W = W_WIDTH + $clog2(N_IN + 1) + 1;
    localparam int MW1   = MEM_WIDTH + 1;
    // Membrane + synapse sum: signed, wide enough for either operand plus a carry.
    localparam int SUM_W = ((ACC_W > MW1) ? ACC_W : MW1) + 1;
    // Common zero-extended width for membrane / parameter comparisons.
    localparam int CMP_W = ((MEM_WIDTH > P_WIDTH) ? MEM_WIDTH : P_WIDTH) + 1;
    localparam logic [MEM_WIDTH-1:0] MEM_MAX = '1;

    logic [MAX_D-1:0]     hist_q [N_IN];
    logic [MAX_D-1:0]     hist_d [N_IN];
    logic [MEM_WIDTH-1:0] mem_q  [N_OUT];
    logic [MEM_WIDTH-1:0] mem_d  [N_OUT];
    logic [P_WIDTH-1:0]   ref_q  [N_OUT];
    logic [P_WIDTH-1:0]   ref_d  [N_OUT];
    logic [N_OUT-1:0]     spike_q;
    logic [N_OUT-1:0]     spike_d;

    logic signed [ACC_W-1:0] syn_sum [N_OUT];

    logic [MAX_D:0]               tap_vec;
    logic [D_WIDTH-1:0]           tap_sel;
    logic signed [W_WIDTH-1:0]    tap_w;

    logic [CMP_W-1:0]             v_ext;
    logic [CMP_W-1:0]             dec_ext;
    logic [MEM_WIDTH-1:0]         u_mem;
    logic signed [SUM_W-1:0]      t_full;
    logic [MEM_WIDTH-1:0]         t_mem;

    // Sum the sign-extended weights of every synapse whose delayed spike is set;
    // tap 0 is the live input, tap d reads history entry d-1.
    always_comb begin
        tap_vec = '0;
        tap_sel = '0;
        tap_w   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            syn_sum[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                tap_vec = {hist_q[i], input_spikes[i]};
                tap_sel = delays[(j*N_IN + i)*D_WIDTH +: D_WIDTH];
                tap_w   = weights[(j*N_IN + i)*W_WIDTH +: W_WIDTH];
                if (tap_vec[tap_sel]) begin
                    syn_sum[j] = syn_sum[j] + ACC_W'(tap_w);
                end
            end
        end
    end

    // Next-state: clear beats enable; an enabled step shifts history and runs
    // each neuron's refractory / leak / integrate / fire update.
    always_comb begin
        hist_d  = hist_q;
        mem_d   = mem_q;
        ref_d   = ref_q;
        spike_d = spike_q;
        v_ext   = '0;
        dec_ext = '0;
        u_mem   = '0;
        t_full  = '0;
        t_mem   = '0;
        if (clear) begin
            for (int i = 0; i < N_IN; i++) begin
                hist_d[i] = '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                mem_d[j] = '0;
                ref_d[j] = '0;
            end
            spike_d = '0;
        end else if (enable) begin
            for (int i = 0; i < N_IN; i++) begin
                hist_d[i] = MAX_D'({hist_q[i], input_spikes[i]});
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (ref_q[j] != '0) begin
                    ref_d[j]   = ref_q[j] - P_WIDTH'(1);
                    mem_d[j]   = '0;
                    spike_d[j] = 1'b0;
                end else begin
                    v_ext   = CMP_W'(mem_q[j]);
                    dec_ext = CMP_W'(decay);
                    if (v_ext >= dec_ext) begin
                        u_mem = MEM_WIDTH'(v_ext - dec_ext);
                    end else begin
                        u_mem = '0;
                    end
                    t_full = $signed({{(SUM_W-MEM_WIDTH){1'b0}}, u_mem}) + SUM_W'(syn_sum[j]);
                    if (t_full[SUM_W-1]) begin
                        t_mem = '0;
                    end else if (t_full[SUM_W-2:MEM_WIDTH] != '0) begin
                        t_mem = MEM_MAX;
                    end else begin
                        t_mem = t_full[MEM_WIDTH-1:0];
                    end
                    if (CMP_W'(t_mem) >= CMP_W'(threshold)) begin
                        spike_d[j] = 1'b1;
                        mem_d[j]   = '0;
                        ref_d[j]   = refractory_period;
                    end else begin
                        spike_d[j] = 1'b0;
                        mem_d[j]   = t_mem;
                    end
                end
            end
        end
    end

    // State registers; reset discards history, membranes, counters and spikes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                hist_q[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                mem_q[j] <= '0;
                ref_q[j] <= '0;
            end
            spike_q <= '0;
        end else begin
            hist_q  <= hist_d;
            mem_q   <= mem_d;
            ref_q   <= ref_d;
            spike_q <= spike_d;
        end
    end

    // Pack the registered membranes onto the flat output bus.
    always_comb begin
        membrane_potential_out = '0;
        for (int j = 0; j < N_OUT; j++) begin
            membrane_potential_out[j*MEM_WIDTH +: MEM_WIDTH] = mem_q[j];
        end
    end

    assign output_spikes = spike_q;

endmodule
